// File: rtl/ppl_skid_buf_pkg.sv
// Shared types for the skid-buffer pipeline stage.
// The state encoding doubles as the occupancy count.
package ppl_skid_buf_pkg;

    typedef enum logic [1:0] {
        PSB_EMPTY = 2'd0,
        PSB_ONE   = 2'd1,
        PSB_FULL  = 2'd2
    } psb_state_t;

    function automatic logic [1:0] occFromState(input psb_state_t state);
        return state;
    endfunction

endpackage

// File: rtl/ppl_skid_buf.sv
// Two-entry elastic pipeline stage (main + skid) with valid/ready on both sides.
// Every output decodes from flops, so there is no combinational path from m_ready to s_ready.
module ppl_skid_buf
    import ppl_skid_buf_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [WIDTH-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic [1:0]       occ
);

    psb_state_t       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             w_acc;
    logic             w_pop;

    assign m_valid = (r_state != PSB_EMPTY);
    assign s_ready = (r_state != PSB_FULL);
    assign m_data  = r_main;
    assign occ     = occFromState(r_state);

    assign w_acc = s_valid & s_ready;
    assign w_pop = m_valid & m_ready;

    // The skid entry only ever holds the payload younger than main, so a pop from FULL promotes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= PSB_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (flush) begin
            r_state <= PSB_EMPTY;
        end else begin
            unique case (r_state)
                PSB_EMPTY: begin
                    if (w_acc) begin
                        r_main  <= s_data;
                        r_state <= PSB_ONE;
                    end
                end
                PSB_ONE: begin
                    if (w_acc && w_pop) begin
                        r_main <= s_data;
                    end else if (w_acc) begin
                        r_skid  <= s_data;
                        r_state <= PSB_FULL;
                    end else if (w_pop) begin
                        r_state <= PSB_EMPTY;
                    end
                end
                PSB_FULL: begin
                    if (w_pop) begin
                        r_main  <= r_skid;
                        r_state <= PSB_ONE;
                    end
                end
                default: r_state <= PSB_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_ppl_skid_buf.sv
// Directed plus random-traffic bench for ppl_skid_buf.
module tb_ppl_skid_buf;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [1:0]       occ;

    int total = 0;
    int bad   = 0;

    ppl_skid_buf #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .occ     (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] d, input logic mr, input logic fl);
        s_valid = v;
        s_data  = d;
        m_ready = mr;
        flush   = fl;
    endtask

    task automatic stepClock();
        @(posedge clk);
        #1;
    endtask

    task automatic checkState(input string tag, input logic [1:0] expOcc, input logic [31:0] expData);
        checkOutput({tag, ".occ"}, {30'd0, occ}, {30'd0, expOcc});
        checkOutput({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, expOcc != 2'd0});
        checkOutput({tag, ".s_ready"}, {31'd0, s_ready}, {31'd0, expOcc != 2'd2});
        if (expOcc != 2'd0) checkOutput({tag, ".m_data"}, m_data, expData);
    endtask

    logic [31:0] q[$];
    logic [31:0] expFront;
    logic        prevStall;
    logic [31:0] prevData;
    logic        pendValid;
    logic        acc;
    logic        pop;

    initial begin
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #12;
        checkState("reset", 2'd0, 32'h0);
        checkOutput("reset.m_data", m_data, 32'h0);
        rst_n = 1'b1;
        stepClock();

        // streaming at full rate
        applyStimulus(1'b1, 32'h11, 1'b1, 1'b0);
        stepClock();
        checkState("stream0", 2'd1, 32'h11);
        s_data = 32'h22;
        stepClock();
        checkState("stream1", 2'd1, 32'h22);
        s_data = 32'h33;
        stepClock();
        checkState("stream2", 2'd1, 32'h33);
        s_valid = 1'b0;
        stepClock();
        checkState("stream_end", 2'd0, 32'h0);

        // fill under stall, then release with 0xC held
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
        stepClock();
        checkState("fill_a", 2'd1, 32'hA);
        s_data = 32'hB;
        stepClock();
        checkState("fill_b", 2'd2, 32'hA);
        s_data = 32'hC;
        stepClock();
        checkState("stall_hold", 2'd2, 32'hA);
        m_ready = 1'b1;
        stepClock();
        checkState("release_b", 2'd1, 32'hB);
        stepClock();
        checkState("release_c", 2'd1, 32'hC);
        s_valid = 1'b0;
        stepClock();
        checkState("release_end", 2'd0, 32'h0);

        // drain from FULL with no new input
        applyStimulus(1'b1, 32'hA, 1'b0, 1'b0);
        stepClock();
        s_data = 32'hB;
        stepClock();
        checkState("drain_full", 2'd2, 32'hA);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        stepClock();
        checkState("drain_one", 2'd1, 32'hB);
        stepClock();
        checkState("drain_empty", 2'd0, 32'h0);

        // flush in FULL with an offered payload
        applyStimulus(1'b1, 32'h1, 1'b0, 1'b0);
        stepClock();
        s_data = 32'h2;
        stepClock();
        checkState("pre_flush_full", 2'd2, 32'h1);
        applyStimulus(1'b1, 32'hD, 1'b0, 1'b1);
        stepClock();
        checkState("flush_full", 2'd0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        stepClock();
        checkState("flush_full_after", 2'd0, 32'h0);

        // flush in ONE with the pop still taken downstream
        applyStimulus(1'b1, 32'h5, 1'b0, 1'b0);
        stepClock();
        checkState("pre_flush_one", 2'd1, 32'h5);
        applyStimulus(1'b1, 32'h6, 1'b1, 1'b1);
        stepClock();
        checkState("flush_one", 2'd0, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        stepClock();
        checkState("flush_one_after", 2'd0, 32'h0);

        // asynchronous reset while FULL and traffic active
        applyStimulus(1'b1, 32'h7, 1'b0, 1'b0);
        stepClock();
        s_data = 32'h8;
        stepClock();
        checkState("pre_reset_full", 2'd2, 32'h7);
        #2;
        rst_n = 1'b0;
        #1;
        checkState("async_reset", 2'd0, 32'h0);
        checkOutput("async_reset.m_data", m_data, 32'h0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
        stepClock();
        rst_n = 1'b1;
        stepClock();

        // random valid/ready traffic against a scoreboard queue
        pendValid = 1'b0;
        prevStall = 1'b0;
        prevData  = 32'h0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            if (!pendValid) begin
                s_valid = ($urandom_range(0, 3) != 0);
                s_data  = $urandom;
            end
            m_ready = ($urandom_range(0, 2) != 0);
            flush   = 1'b0;
            #1;
            checkOutput("rand.occ", {30'd0, occ}, q.size());
            if (prevStall) begin
                checkOutput("rand.stable_valid", {31'd0, m_valid}, 32'd1);
                checkOutput("rand.stable_data", m_data, prevData);
            end
            acc = s_valid & s_ready;
            pop = m_valid & m_ready;
            if (pop) begin
                expFront = (q.size() > 0) ? q[0] : 32'hDEAD_BEEF;
                checkOutput("rand.order", m_data, expFront);
            end
            prevStall = m_valid & ~m_ready;
            prevData  = m_data;
            pendValid = s_valid & ~s_ready;
            @(posedge clk);
            if (pop && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(s_data);
            #1;
        end
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) stepClock();
        checkOutput("rand.final_occ", {30'd0, occ}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
